multicycle_control: RTL and testbench

//  Moore FSM sequencing the multicycle RV32 datapath: one shared ALU, one shared memory port, IR, PC.

---
 rtl/multicycle_control.sv | 195 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// multicycle_control: Moore-style control FSM for a multicycle RV32 datapath
// (one shared ALU, one shared memory port, IR, PC). Handles R-type, lw, sw, beq.
// Optional performance counters are compiled in when MCCTRL_PERF_EN is defined.
//
// Memory handshake: mem_read/mem_write act as the request. They stay high and
// stable from the first cycle of an access up to and including the cycle in
// which mem_ready is high. That cycle completes the access, and the FSM
// advances on the next edge. mem_ready is ignored in every state that makes no
// request.
module multicycle_control #(
    parameter logic [6:0] OPC_R   = 7'b0110011,
    parameter logic [6:0] OPC_LW  = 7'b0000011,
    parameter logic [6:0] OPC_SW  = 7'b0100011,
    parameter logic [6:0] OPC_BEQ = 7'b1100011
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_en,
    output logic        pc_source,
    output logic        ir_write,
    output logic        iord,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic        illegal,
    output logic [3:0]  state
`ifdef MCCTRL_PERF_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
`endif
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_MEMADR = 4'd3;
    localparam logic [3:0] S_MEMRD  = 4'd4;
    localparam logic [3:0] S_MEMWB  = 4'd5;
    localparam logic [3:0] S_MEMWR  = 4'd6;
    localparam logic [3:0] S_EXEC   = 4'd7;
    localparam logic [3:0] S_ALUWB  = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;
    localparam logic [3:0] S_TRAP   = 4'd15;

    logic [3:0] state_q;
    logic [3:0] state_d;

    // State register; an asynchronous reset forces IDLE at once, so every output decodes to 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; the opcode is only looked at in DECODE and MEMADR.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                if (opcode == OPC_LW || opcode == OPC_SW) state_d = S_MEMADR;
                else if (opcode == OPC_R)                 state_d = S_EXEC;
                else if (opcode == OPC_BEQ)               state_d = S_BRANCH;
                else                                      state_d = S_TRAP;
            end
            S_MEMADR: begin
                // The IR is stable, so only lw/sw can arrive here; anything else is treated as illegal.
                if (opcode == OPC_LW)      state_d = S_MEMRD;
                else if (opcode == OPC_SW) state_d = S_MEMWR;
                else                       state_d = S_TRAP;
            end
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  if (mem_ready) state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output decode: everything comes from the state except pc_en/ir_write, which use mem_ready and zero.
    always_comb begin
        pc_en      = 1'b0;
        pc_source  = 1'b0;
        ir_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                // The ALU computes PC+4 while memory returns the instruction.
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_en     = mem_ready;
            end
            S_DECODE: begin
                // Branch target oldPC+imm goes into ALUOut speculatively.
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                // rs1-rs2 is computed here; zero selects whether ALUOut (target) loads the PC.
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                pc_source = 1'b1;
                pc_en     = zero;
            end
            S_TRAP: begin
                illegal = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign state = state_q;

`ifdef MCCTRL_PERF_EN
    logic [31:0] cycle_cnt_q;
    logic [31:0] cycle_cnt_d;
    logic [31:0] instret_cnt_q;
    logic [31:0] instret_cnt_d;
    logic        retire;

    assign retire = (state_q == S_MEMWB) || (state_q == S_ALUWB) ||
                    (state_q == S_BRANCH) ||
                    ((state_q == S_MEMWR) && mem_ready);

    // Counter next values; both wrap naturally at 32 bits.
    always_comb begin
        cycle_cnt_d   = cycle_cnt_q;
        instret_cnt_d = instret_cnt_q;
        if (state_q != S_IDLE && state_q != S_TRAP) cycle_cnt_d = cycle_cnt_q + 32'd1;
        if (retire) instret_cnt_d = instret_cnt_q + 32'd1;
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt_q   <= 32'd0;
            instret_cnt_q <= 32'd0;
        end else begin
            cycle_cnt_q   <= cycle_cnt_d;
            instret_cnt_q <= instret_cnt_d;
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control. The reference model expands each
// instruction into its list of phases, using the wait counts and the zero flag
// supplied by the stimulus. Every phase becomes one expected cycle. A
// negedge process compares the DUT against each queued cycle. A few literal
// checks pin down reset, trap, pulse counts and, with MCCTRL_PERF_EN, the
// counters.
module tb_multicycle_control;

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_LW  = 7'b0000011;
  localparam logic [6:0] OPC_SW  = 7'b0100011;
  localparam logic [6:0] OPC_BEQ = 7'b1100011;
  localparam logic [6:0] OPC_BAD = 7'b1111111;

  localparam int P_IDLE = 0, P_FETCH = 1, P_DECODE = 2, P_MEMADR = 3, P_MEMRD = 4;
  localparam int P_MEMWB = 5, P_MEMWR = 6, P_EXEC = 7, P_ALUWB = 8, P_BRANCH = 9, P_TRAP = 15;
  localparam int W = 19;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic zero = 1'b0;
  logic mem_ready = 1'b0;
  logic pc_en, pc_source, ir_write, iord, mem_read, mem_write, reg_write, mem_to_reg;
  logic [1:0] alu_src_a, alu_src_b, alu_op;
  logic illegal;
  logic [3:0] state;
`ifdef MCCTRL_PERF_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int ir_pulses = 0;
  int rw_pulses = 0;
  logic [W-1:0] exp_q[$];

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .pc_source(pc_source), .ir_write(ir_write), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .illegal(illegal), .state(state)
`ifdef MCCTRL_PERF_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] actual_vec();
    return {state, pc_en, pc_source, ir_write, iord, mem_read, mem_write,
            reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op, illegal};
  endfunction

  // Expected outputs for one phase, taken from the per-phase output table.
  function automatic logic [W-1:0] phase_vec(input int ph, input logic rdy, input logic z);
    logic pe, ps, irw, io, mr, mw, rw, m2r, ill;
    logic [1:0] sa, sb, op;
    pe = 0; ps = 0; irw = 0; io = 0; mr = 0; mw = 0; rw = 0; m2r = 0; ill = 0;
    sa = 2'b00; sb = 2'b00; op = 2'b00;
    case (ph)
      P_FETCH:  begin mr = 1; sb = 2'b01; irw = rdy; pe = rdy; end
      P_DECODE: begin sa = 2'b01; sb = 2'b10; end
      P_MEMADR: begin sa = 2'b10; sb = 2'b10; end
      P_MEMRD:  begin mr = 1; io = 1; end
      P_MEMWB:  begin rw = 1; m2r = 1; end
      P_MEMWR:  begin mw = 1; io = 1; end
      P_EXEC:   begin sa = 2'b10; op = 2'b10; end
      P_ALUWB:  begin rw = 1; end
      P_BRANCH: begin sa = 2'b10; op = 2'b01; ps = 1; pe = z; end
      P_TRAP:   begin ill = 1; end
      default:  begin end
    endcase
    return {ph[3:0], pe, ps, irw, io, mr, mw, rw, m2r, sa, sb, op, ill};
  endfunction

  // scoreboard compare: one expected entry per cycle, checked mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      logic [W-1:0] a;
      e = exp_q.pop_front();
      a = actual_vec();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle_vec t=%0t state=%0d got=%05h exp=%05h", $time, state, a, e);
      end
      checks++;
      if (mem_read && mem_write) begin
        errors++;
        $display("FAIL rd_wr_exclusive t=%0t got both high exp not both", $time);
      end
      if (ir_write === 1'b1) ir_pulses++;
      if (reg_write === 1'b1) rw_pulses++;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // driver: one cycle with given inputs and expected phase
  task automatic cycle(input int ph, input logic rdy, input logic z);
    mem_ready = rdy;
    zero = z;
    exp_q.push_back(phase_vec(ph, rdy, z));
    @(posedge clk);
    #1;
  endtask

  // Instruction-level model: expand one instruction into its phases.
  task automatic run_instr(input logic [6:0] op, input int fw, input int mw,
                           input logic z, output int len);
    opcode = op;
    len = 0;
    for (int i = 0; i < fw; i++) begin cycle(P_FETCH, 1'b0, z); len++; end
    cycle(P_FETCH, 1'b1, z); len++;
    cycle(P_DECODE, 1'b1, z); len++;
    if (op == OPC_R) begin
      cycle(P_EXEC, 1'b1, z); cycle(P_ALUWB, 1'b1, z); len += 2;
    end else if (op == OPC_LW) begin
      cycle(P_MEMADR, 1'b1, z); len++;
      for (int i = 0; i < mw; i++) begin cycle(P_MEMRD, 1'b0, z); len++; end
      cycle(P_MEMRD, 1'b1, z); cycle(P_MEMWB, 1'b1, z); len += 2;
    end else if (op == OPC_SW) begin
      cycle(P_MEMADR, 1'b1, z); len++;
      for (int i = 0; i < mw; i++) begin cycle(P_MEMWR, 1'b0, z); len++; end
      cycle(P_MEMWR, 1'b1, z); len++;
    end else if (op == OPC_BEQ) begin
      cycle(P_BRANCH, 1'b1, z); len++;
    end else begin
      cycle(P_TRAP, 1'b1, z); len++;
    end
  endtask

  // Reset sequence: outputs must all be 0 while reset is high; then one IDLE cycle.
  task automatic do_reset();
    reset = 1'b1;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    check("reset_outputs", {13'd0, actual_vec()}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cycle(P_IDLE, 1'b1, 1'b0);
  endtask

  initial begin
    int len;
    // 1: R-type after reset, states 0,1,2,7,8,1
    do_reset();
`ifdef MCCTRL_PERF_EN
    check("perf_reset_cycle", cycle_cnt, 32'd0);
    check("perf_reset_instret", instret_cnt, 32'd0);
`endif
    rw_pulses = 0;
    run_instr(OPC_R, 0, 0, 1'b0, len);
    check("lat_r", len, 32'd4);
    check("r_reg_write_pulses", rw_pulses, 32'd1);
    check("r_back_to_fetch", state, 32'd1);

    // 2: lw, FETCH waits 2, MEMRD waits 1
    ir_pulses = 0;
    rw_pulses = 0;
    run_instr(OPC_LW, 2, 1, 1'b0, len);
    check("lat_lw_waits", len, 32'd8);
    check("lw_ir_write_pulses", ir_pulses, 32'd1);
    check("lw_reg_write_pulses", rw_pulses, 32'd1);

    // 3: beq taken and not taken
    run_instr(OPC_BEQ, 0, 0, 1'b1, len);
    check("lat_beq", len, 32'd3);
    run_instr(OPC_BEQ, 0, 0, 1'b0, len);
    check("beq_nt_to_fetch", state, 32'd1);

    // 4: sw with one wait; reg_write never asserted
    rw_pulses = 0;
    run_instr(OPC_SW, 0, 1, 1'b0, len);
    check("lat_sw_wait", len, 32'd5);
    check("sw_reg_write_pulses", rw_pulses, 32'd0);
    run_instr(OPC_LW, 0, 0, 1'b1, len);
    check("lat_lw", len, 32'd5);

    // 5: illegal opcode -> TRAP, sticky for 20 more cycles with varied inputs
    run_instr(OPC_BAD, 0, 0, 1'b0, len);
    for (int i = 0; i < 20; i++) begin
      opcode = 7'($urandom_range(0, 127));
      cycle(P_TRAP, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    check("trap_illegal_literal", illegal, 32'd1);
`ifdef MCCTRL_PERF_EN
    // Reset, then 3 back-to-back R-types: 12 counted cycles, 3 retired.
    do_reset();
    for (int k = 0; k < 3; k++) run_instr(OPC_R, 0, 0, 1'b0, len);
    check("perf_cycle_12", cycle_cnt, 32'd12);
    check("perf_instret_3", instret_cnt, 32'd3);
`endif

    // Reset clears illegal; 6: reset asserted in the middle of MEMRD
    do_reset();
    check("reset_clears_illegal", illegal, 32'd0);
    opcode = OPC_LW;
    cycle(P_FETCH, 1'b1, 1'b0);
    cycle(P_DECODE, 1'b1, 1'b0);
    cycle(P_MEMADR, 1'b1, 1'b0);
    mem_ready = 1'b0;
    exp_q.push_back(phase_vec(P_MEMRD, 1'b0, 1'b0));
    @(negedge clk);
    #1;
    check("memrd_read_before_reset", mem_read, 32'd1);
    reset = 1'b1;
    #1;
    check("midreset_state", state, 32'd0);
    check("midreset_outputs", {13'd0, actual_vec()}, 32'd0);
`ifdef MCCTRL_PERF_EN
    check("midreset_cycle_cnt", cycle_cnt, 32'd0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;
    cycle(P_IDLE, 1'b1, 1'b0);
    run_instr(OPC_R, 1, 0, 1'b0, len);
    check("lat_r_after_reset", len, 32'd5);

    @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
